window_scan_3: RTL and testbench

WINDOW_SCAN_3 -- requirements
Module: window_scan_3

---
 rtl/win_scan_pkg.sv | 44 ++++
 rtl/window_extract.sv | 46 ++++
 rtl/window_scan_3.sv | 142 ++++++++++++++
 tb/tb_window_scan_3.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/win_scan_pkg.sv
// win_scan_pkg: shared types and constants for the 3x3 window scanner.
//   state_e           : scanner FSM states
//   K                 : window edge length
//   PAD               : border padding (1 when WINDOW_SCAN_PAD_EN is defined)
//   COORD_W           : width of the row/column coordinates
//   FIRST_ROW/COL     : first window centre
//   last_row/last_col : last window centre for a given plane size
//   LAST_ROW_DEF/COL  : last centre for the default 8x6 plane
// Configuration macro: WINDOW_SCAN_PAD_EN
package win_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int K = 3;

`ifdef WINDOW_SCAN_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    localparam int COORD_W = 4;

    // With padding the centre may sit on the border; without it the
    // centre must keep one pixel of margin on every side.
    localparam int FIRST_ROW = 1 - PAD;
    localparam int FIRST_COL = 1 - PAD;

    function automatic int last_row(input int height);
        return height - 2 + PAD;
    endfunction

    function automatic int last_col(input int width);
        return width - 2 + PAD;
    endfunction

    localparam int LAST_ROW_DEF = 8 - 2 + PAD;
    localparam int LAST_COL_DEF = 6 - 2 + PAD;

endpackage

// File: rtl/window_extract.sv
// window_extract: combinational 3x3 tap gather from one channel plane.
//   plane : HEIGHT x WIDTH elements of DATA_WIDTH bits
//   row   : centre row
//   col   : centre column
//   win   : 3x3 window, win[0][0] is top-left; taps outside the plane read 0
module window_extract
    import win_scan_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 6,
    parameter int HEIGHT     = 8
) (
    input  logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] plane,
    input  logic [COORD_W-1:0]                           row,
    input  logic [COORD_W-1:0]                           col,
    output logic [K-1:0][K-1:0][DATA_WIDTH-1:0]          win
);

    localparam int RIW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CIW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    for (genvar gi = 0; gi < K; gi++) begin : g_row
        // Offset by +1 so the tap above row 0 is 0 rather than a wrapped value.
        logic [COORD_W:0] rp;
        logic [COORD_W:0] rr;
        logic             row_ok;

        assign rp     = {1'b0, row} + (COORD_W+1)'(gi);
        assign rr     = rp - (COORD_W+1)'(1);
        assign row_ok = (rp != '0) && (rr < (COORD_W+1)'(HEIGHT));

        for (genvar gj = 0; gj < K; gj++) begin : g_col
            logic [COORD_W:0] cp;
            logic [COORD_W:0] cc;
            logic             col_ok;

            assign cp     = {1'b0, col} + (COORD_W+1)'(gj);
            assign cc     = cp - (COORD_W+1)'(1);
            assign col_ok = (cp != '0) && (cc < (COORD_W+1)'(WIDTH));

            assign win[gi][gj] = (row_ok && col_ok) ? plane[rr[RIW-1:0]][cc[CIW-1:0]]
                                                    : '0;
        end
    end

endmodule

// File: rtl/window_scan_3.sv
// window_scan_3: streams every 3x3 window of a CHANNELS-deep plane stack in
// row-major centre order over a valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   frame_valid : pulse, plane_in is complete and held stable while busy
//   plane_in    : CHANNELS x HEIGHT x WIDTH elements
//   busy        : a frame is being scanned
//   win_valid / win_ready : window handshake
//   win_out     : CHANNELS x 3 x 3 window, [0][0] top-left
//   win_row/col : centre of the current window
//   win_last    : current window is the final one of the frame
//   frame_ovf   : sticky, frame_valid seen while not idle
// Configuration macro: WINDOW_SCAN_PAD_EN (zero padding of one pixel).
module window_scan_3
    import win_scan_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 64,
    parameter int WIDTH      = 6,
    parameter int HEIGHT     = 8
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   frame_valid,
    input  logic [CHANNELS-1:0][HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] plane_in,
    output logic                                                   busy,
    output logic                                                   win_valid,
    input  logic                                                   win_ready,
    output logic [CHANNELS-1:0][K-1:0][K-1:0][DATA_WIDTH-1:0]      win_out,
    output logic [COORD_W-1:0]                                     win_row,
    output logic [COORD_W-1:0]                                     win_col,
    output logic                                                   win_last,
    output logic                                                   frame_ovf
);

    localparam int LAST_ROW = last_row(HEIGHT);
    localparam int LAST_COL = last_col(WIDTH);

    typedef logic [CHANNELS-1:0][K-1:0][K-1:0][DATA_WIDTH-1:0] win_t;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic               win_valid_q, win_valid_d;
    logic               win_last_q, win_last_d;
    logic               frame_ovf_q, frame_ovf_d;
    win_t               win_q, win_d;
    win_t               ext_win;
    logic               load;

    // Extractors look at the coordinate being loaded this edge, so the
    // registered window always matches the registered coordinate.
    for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_ch
        window_extract #(
            .DATA_WIDTH (DATA_WIDTH),
            .WIDTH      (WIDTH),
            .HEIGHT     (HEIGHT)
        ) u_extract (
            .plane (plane_in[gc]),
            .row   (row_d),
            .col   (col_d),
            .win   (ext_win[gc])
        );
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        load        = 1'b0;
        frame_ovf_d = frame_ovf_q | (frame_valid & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    state_d     = SCAN;
                    row_d       = COORD_W'(FIRST_ROW);
                    col_d       = COORD_W'(FIRST_COL);
                    win_valid_d = 1'b1;
                    load        = 1'b1;
                end
            end
            SCAN: begin
                // win_valid is always high in SCAN, so ready alone is the handshake.
                if (win_ready) begin
                    if (win_last_q) begin
                        state_d     = DRAIN;
                        win_valid_d = 1'b0;
                    end else begin
                        load = 1'b1;
                        if (col_q == COORD_W'(LAST_COL)) begin
                            col_d = COORD_W'(FIRST_COL);
                            row_d = row_q + COORD_W'(1);
                        end else begin
                            col_d = col_q + COORD_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                win_valid_d = 1'b0;
            end
        endcase

        win_d      = load ? ext_win : win_q;
        win_last_d = load ? ((row_d == COORD_W'(LAST_ROW)) && (col_d == COORD_W'(LAST_COL)))
                          : win_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            frame_ovf_q <= 1'b0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            frame_ovf_q <= frame_ovf_d;
            win_q       <= win_d;
        end
    end

    assign busy      = (state_q == SCAN);
    assign win_valid = win_valid_q;
    assign win_out   = win_q;
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign win_last  = win_last_q;
    assign frame_ovf = frame_ovf_q;

endmodule

// File: tb/tb_window_scan_3.sv
module tb_window_scan_3;

    localparam int DW = 32;
    localparam int CH = 4;
    localparam int W  = 6;
    localparam int H  = 8;
`ifdef WINDOW_SCAN_PAD_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int R0   = 1 - P;
    localparam int R1   = H - 2 + P;
    localparam int C0   = 1 - P;
    localparam int C1   = W - 2 + P;
    localparam int NCOL = C1 - C0 + 1;
    localparam int NWIN = (R1 - R0 + 1) * NCOL;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_valid;
    logic win_ready;
    logic [CH-1:0][H-1:0][W-1:0][DW-1:0] plane_in;
    logic busy, win_valid, win_last, frame_ovf;
    logic [CH-1:0][2:0][2:0][DW-1:0] win_out;
    logic [3:0] win_row, win_col;

    int vectors = 0;
    int errors  = 0;
    int pl[CH][H][W];

    window_scan_3 #(.DATA_WIDTH(DW), .CHANNELS(CH), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .plane_in(plane_in),
        .busy(busy), .win_valid(win_valid), .win_ready(win_ready), .win_out(win_out),
        .win_row(win_row), .win_col(win_col), .win_last(win_last), .frame_ovf(frame_ovf)
    );

    always #5 clk = ~clk;

    task automatic apply_plane();
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < H; r++)
                for (int x = 0; x < W; x++)
                    plane_in[c][r][x] = DW'(pl[c][r][x]);
    endtask

    task automatic rand_plane();
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < H; r++)
                for (int x = 0; x < W; x++)
                    pl[c][r][x] = int'($urandom);
        apply_plane();
    endtask

    // Reference: window centre k in row-major order, taps outside plane are 0.
    function automatic int exp_tap(int c, int r, int x, int i, int j);
        int rr = r + i - 1;
        int cc = x + j - 1;
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 0;
        return pl[c][rr][cc];
    endfunction

    function automatic bit win_matches(int k);
        int r = R0 + k / NCOL;
        int x = C0 + k % NCOL;
        if (win_row !== 4'(r) || win_col !== 4'(x)) return 1'b0;
        if (win_last !== (k == NWIN - 1)) return 1'b0;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    if (win_out[c][i][j] !== DW'(exp_tap(c, r, x, i, j))) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; frame_valid = 1'b0; win_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_frame();
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    // Accept everything until the frame ends; returns windows seen.
    task automatic finish_frame(output int n);
        int cyc = 0;
        n = 0;
        win_ready = 1'b1;
        while (busy && cyc < 1000) begin
            if (win_valid) n++;
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_valid = 1'b0; win_ready = 1'b0;
        rand_plane();
        @(negedge clk);
        vectors++;
        if (win_valid !== 1'b0 || busy !== 1'b0 || win_last !== 1'b0 || frame_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b b=%b l=%b o=%b need all 0", win_valid, busy, win_last, frame_ovf);
        end
        vectors++;
        if (win_row !== 4'd0 || win_col !== 4'd0 || win_out !== '0) begin
            errors++;
            $display("FAIL reset_data got row=%0d col=%0d out_nonzero=%b need 0", win_row, win_col, win_out != '0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pattern_scan();
        int k = 0, cyc = 0;
        int ex[3][3];
`ifdef WINDOW_SCAN_PAD_EN
        ex = '{'{0, 0, 0}, '{0, 0, 1}, '{0, 6, 7}};
`else
        ex = '{'{0, 1, 2}, '{6, 7, 8}, '{12, 13, 14}};
`endif
        rand_plane();
        for (int r = 0; r < H; r++)
            for (int x = 0; x < W; x++)
                pl[0][r][x] = r * 6 + x;
        apply_plane();
        win_ready = 1'b1;
        start_frame();
        vectors++;
        if (win_valid !== 1'b1 || busy !== 1'b1 || win_row !== 4'(R0) || win_col !== 4'(C0)) begin
            errors++;
            $display("FAIL first_window got v=%b b=%b (%0d,%0d) need v=1 b=1 (%0d,%0d)",
                     win_valid, busy, win_row, win_col, R0, C0);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                vectors++;
                if (win_out[0][i][j] !== DW'(ex[i][j])) begin
                    errors++;
                    $display("FAIL first_tap[%0d][%0d] got %0d need %0d", i, j, win_out[0][i][j], ex[i][j]);
                end
            end
        while (k < NWIN && cyc < 500) begin
            vectors++;
            if (win_valid !== 1'b1 || !win_matches(k)) begin
                errors++;
                $display("FAIL pattern_win k=%0d got v=%b (%0d,%0d) need v=1 (%0d,%0d)",
                         k, win_valid, win_row, win_col, R0 + k / NCOL, C0 + k % NCOL);
            end
            if (k == NWIN - 1) begin
                vectors++;
                if (win_row !== 4'(H - 2 + P) || win_col !== 4'(W - 2 + P) || win_last !== 1'b1) begin
                    errors++;
                    $display("FAIL last_coord got (%0d,%0d) last=%b need (%0d,%0d) last=1",
                             win_row, win_col, win_last, H - 2 + P, W - 2 + P);
                end
            end
            k++;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (k != NWIN || cyc != NWIN) begin
            errors++;
            $display("FAIL pattern_count got %0d in %0d cycles need %0d", k, cyc, NWIN);
        end
        vectors++;
        if (busy !== 1'b0 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop got b=%b v=%b need 0 0", busy, win_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_random_ready();
        int k = 0, cyc = 0;
        rand_plane();
        start_frame();
        while (k < NWIN && cyc < 2000) begin
            vectors++;
            if (win_valid !== 1'b1 || !win_matches(k)) begin
                errors++;
                $display("FAIL rand_win k=%0d got v=%b (%0d,%0d) need v=1 (%0d,%0d)",
                         k, win_valid, win_row, win_col, R0 + k / NCOL, C0 + k % NCOL);
            end
            win_ready = 1'($urandom_range(0, 1));
            if (win_ready) k++;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (k != NWIN || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_count got %0d busy=%b need %0d busy=0", k, busy, NWIN);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int k = 0, cyc = 0, stall = 0;
        logic [CH-1:0][2:0][2:0][DW-1:0] snap_w;
        logic [3:0] snap_r, snap_c;
        rand_plane();
        start_frame();
        while (k < NWIN && cyc < 500) begin
            vectors++;
            if (win_valid !== 1'b1 || !win_matches(k)) begin
                errors++;
                $display("FAIL bp_win k=%0d got v=%b (%0d,%0d) need v=1 (%0d,%0d)",
                         k, win_valid, win_row, win_col, R0 + k / NCOL, C0 + k % NCOL);
            end
            if (k == 5 && stall > 0) begin
                vectors++;
                if (win_out !== snap_w || win_row !== snap_r || win_col !== snap_c) begin
                    errors++;
                    $display("FAIL bp_hold got (%0d,%0d) need (%0d,%0d) data_same=%b",
                             win_row, win_col, snap_r, snap_c, win_out == snap_w);
                end
            end
            if (k == 5 && stall < 3) begin
                if (stall == 0) begin
                    snap_w = win_out; snap_r = win_row; snap_c = win_col;
                end
                stall++;
                win_ready = 1'b0;
            end else begin
                win_ready = 1'b1;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (k != NWIN || cyc != NWIN + 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got %0d in %0d cycles need %0d in %0d", k, cyc, NWIN, NWIN + 3);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int k = 0, cyc = 0, n;
        do_reset();
        rand_plane();
        start_frame();
        while (k < NWIN && cyc < 500) begin
            vectors++;
            if (win_valid !== 1'b1 || !win_matches(k)) begin
                errors++;
                $display("FAIL ovf_win k=%0d got v=%b (%0d,%0d) need v=1 (%0d,%0d)",
                         k, win_valid, win_row, win_col, R0 + k / NCOL, C0 + k % NCOL);
            end
            frame_valid = (k == 10);
            win_ready = 1'b1;
            k++;
            @(negedge clk);
            cyc++;
        end
        frame_valid = 1'b0;
        vectors++;
        if (k != NWIN || cyc != NWIN || frame_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_frame got %0d windows ovf=%b need %0d ovf=1", k, frame_ovf, NWIN);
        end
        @(negedge clk);
        rand_plane();
        start_frame();
        vectors++;
        if (win_valid !== 1'b1 || !win_matches(0) || frame_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_next_start got v=%b (%0d,%0d) ovf=%b need v=1 (%0d,%0d) ovf=1",
                     win_valid, win_row, win_col, frame_ovf, R0, C0);
        end
        finish_frame(n);
        vectors++;
        if (n != NWIN || frame_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %0d windows ovf=%b need %0d ovf=1", n, frame_ovf, NWIN);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0, cyc = 0, n;
        rand_plane();
        start_frame();
        win_ready = 1'b1;
        while (k < 20 && cyc < 500) begin
            if (win_valid) k++;
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (win_valid !== 1'b0 || busy !== 1'b0 || frame_ovf !== 1'b0 || win_row !== 4'd0 || win_col !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset got v=%b b=%b o=%b (%0d,%0d) need 0 0 0 (0,0)",
                     win_valid, busy, frame_ovf, win_row, win_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (win_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet got v=%b b=%b need 0 0", win_valid, busy);
        end
        rand_plane();
        start_frame();
        vectors++;
        if (win_valid !== 1'b1 || !win_matches(0)) begin
            errors++;
            $display("FAIL restart got v=%b (%0d,%0d) need v=1 (%0d,%0d)", win_valid, win_row, win_col, R0, C0);
        end
        finish_frame(n);
        vectors++;
        if (n != NWIN) begin
            errors++;
            $display("FAIL restart_count got %0d need %0d", n, NWIN);
        end
    endtask

    task automatic test_drain_frame();
        int n;
        do_reset();
        rand_plane();
        start_frame();
        finish_frame(n);
        // finish_frame returns one cycle into IDLE; rerun and stop at DRAIN.
        rand_plane();
        start_frame();
        win_ready = 1'b1;
        n = 0;
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
        // Now in DRAIN: this pulse lands on the DRAIN->IDLE edge.
        frame_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (win_valid !== 1'b0 || busy !== 1'b0 || frame_ovf !== 1'b1) begin
            errors++;
            $display("FAIL drain_fv got v=%b b=%b o=%b need 0 0 1", win_valid, busy, frame_ovf);
        end
        rand_plane();
        @(negedge clk);
        frame_valid = 1'b0;
        vectors++;
        if (win_valid !== 1'b1 || busy !== 1'b1 || !win_matches(0)) begin
            errors++;
            $display("FAIL drain_restart got v=%b b=%b (%0d,%0d) need 1 1 (%0d,%0d)",
                     win_valid, busy, win_row, win_col, R0, C0);
        end
        finish_frame(n);
        vectors++;
        if (n != NWIN) begin
            errors++;
            $display("FAIL drain_restart_count got %0d need %0d", n, NWIN);
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_valid = 1'b0; win_ready = 1'b0; plane_in = '0;
        test_reset();
        test_pattern_scan();
        test_random_ready();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_drain_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
